// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI through the TLB ports and issues CP0 writeback strobes.
// Optional macro TLB_REFETCH_EN enables the refetch pulse on TLBR/TLBWI commit.
module tlb_op_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [1:0]    op_type,
    input  logic          flush,
    output logic          busy,
    output logic          op_done,
    input  logic [31:0]   cp0_entryhi,
    input  logic [IW-1:0] cp0_index,
    input  logic [77:0]   cp0_wentry,
    output logic [18:0]   s_vpn2,
    output logic [7:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic [IW-1:0] r_index,
    input  logic [77:0]   r_entry,
    output logic          w_en,
    output logic [IW-1:0] w_index,
    output logic [77:0]   w_entry,
    output logic          tlbp_wen,
    output logic [31:0]   tlbp_index,
    output logic          tlbr_wen,
    output logic [77:0]   tlbr_entry,
    output logic          refetch
);
    typedef enum logic [2:0] {IDLE, SRCH, RD, RDW, WR, COMMIT} state_e;

    state_e        state_q, state_d;
    logic [1:0]    type_q, type_d;
    logic [18:0]   vpn2_q, vpn2_d;
    logic [7:0]    asid_q, asid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [77:0]   went_q, went_d;
    logic [31:0]   tlbp_index_q, tlbp_index_d;
    logic [77:0]   tlbr_entry_q, tlbr_entry_d;
    logic          accept, commit, unused_ehi;

    assign unused_ehi = ^cp0_entryhi[12:8];
    assign op_ready   = (state_q == IDLE) && !flush;
    assign accept     = op_valid && op_ready;
    assign commit     = (state_q == COMMIT) && !flush;
    assign busy       = state_q != IDLE;
    assign op_done    = commit;
    assign tlbp_wen   = commit && (type_q == 2'b01);
    assign tlbr_wen   = commit && (type_q == 2'b10);
    assign w_en       = (state_q == WR) && !flush;
    assign s_vpn2     = vpn2_q;
    assign s_asid     = asid_q;
    assign r_index    = idx_q;
    assign w_index    = idx_q;
    assign w_entry    = went_q;
    assign tlbp_index = tlbp_index_q;
    assign tlbr_entry = tlbr_entry_q;
`ifdef TLB_REFETCH_EN
    assign refetch    = commit && type_q[1];
`else
    assign refetch    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        vpn2_d       = vpn2_q;
        asid_d       = asid_q;
        idx_d        = idx_q;
        went_d       = went_q;
        tlbp_index_d = tlbp_index_q;
        tlbr_entry_d = tlbr_entry_q;
        if (accept) begin
            type_d  = op_type;
            vpn2_d  = cp0_entryhi[31:13];
            asid_d  = cp0_entryhi[7:0];
            idx_d   = cp0_index;
            went_d  = cp0_wentry;
            state_d = op_type == 2'b01 ? SRCH : op_type == 2'b10 ? RD : op_type == 2'b11 ? WR : COMMIT;
        end
        // A flushed op leaves the CP0-visible result registers untouched.
        if (state_q == SRCH && !flush)
            tlbp_index_d = {!s_found, {(31-IW){1'b0}}, s_found ? s_index : {IW{1'b0}}};
        if (state_q == RDW && !flush)
            tlbr_entry_d = r_entry;
        if (state_q != IDLE)
            state_d = (flush || state_q == COMMIT) ? IDLE : state_q == RD ? RDW : COMMIT;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            type_q       <= '0;
            vpn2_q       <= '0;
            asid_q       <= '0;
            idx_q        <= '0;
            went_q       <= '0;
            tlbp_index_q <= '0;
            tlbr_entry_q <= '0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            vpn2_q       <= vpn2_d;
            asid_q       <= asid_d;
            idx_q        <= idx_d;
            went_q       <= went_d;
            tlbp_index_q <= tlbp_index_d;
            tlbr_entry_q <= tlbr_entry_d;
        end
    end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed and randomized checks of tlb_op_ctrl against a cycle-timeline model.
module tb_tlb_op_ctrl;
    localparam int IW = 4;

    logic          clk = 0, resetn = 0;
    logic          op_valid = 0, flush = 0;
    logic [1:0]    op_type = 0;
    logic [31:0]   cp0_entryhi = 0;
    logic [IW-1:0] cp0_index = 0;
    logic [77:0]   cp0_wentry = 0;
    logic          s_found = 0;
    logic [IW-1:0] s_index = 0;
    logic [77:0]   r_entry = 0;
    logic          op_ready, busy, op_done, w_en, tlbp_wen, tlbr_wen, refetch;
    logic [18:0]   s_vpn2;
    logic [7:0]    s_asid;
    logic [IW-1:0] r_index, w_index;
    logic [77:0]   w_entry, tlbr_entry;
    logic [31:0]   tlbp_index;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
        .flush(flush), .busy(busy), .op_done(op_done), .cp0_entryhi(cp0_entryhi),
        .cp0_index(cp0_index), .cp0_wentry(cp0_wentry), .s_vpn2(s_vpn2), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index), .r_index(r_index), .r_entry(r_entry),
        .w_en(w_en), .w_index(w_index), .w_entry(w_entry), .tlbp_wen(tlbp_wen),
        .tlbp_index(tlbp_index), .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry), .refetch(refetch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [77:0] mem [16];

    // Model: cycles elapsed since accept, commit at a per-type latency.
    logic          m_busy = 0;
    int            m_t = 0;
    logic [1:0]    m_type = 0;
    logic [31:0]   m_ehi = 0;
    logic [IW-1:0] m_idx = 0;
    logic [77:0]   m_went = 0, m_tr = 0;
    logic [31:0]   m_tp = 0;
    logic          comm, done, exp_ref;
    logic [IW:0]   sr;
    logic [31:0]   e;
    int            k;

    task automatic chk(input string nm, input logic [77:0] act, input logic [77:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lat(input logic [1:0] t);
        return t == 2'd0 ? 1 : t == 2'd2 ? 3 : 2;
    endfunction

    function automatic logic [IW:0] search(input logic [18:0] v, input logic [7:0] a);
        logic [IW:0] r = '0;
        for (int i = 15; i >= 0; i--)
            if (mem[i][77:59] == v && mem[i][58:51] == a) r = {1'b1, 4'(i)};
        return r;
    endfunction

    function automatic logic [77:0] mk(input logic [31:0] ehi, input logic [50:0] lo);
        return {ehi[31:13], ehi[7:0], lo};
    endfunction

    always @(posedge clk) r_entry <= mem[r_index];

    always @(negedge clk) begin
        if (!resetn) begin
            m_busy = 0; m_t = 0; m_type = 0; m_ehi = 0; m_idx = 0; m_went = 0; m_tp = 0; m_tr = 0;
            for (int i = 0; i < 16; i++) mem[i] = {19'h70000 + 19'(i), 8'hFF, 51'(i)};
        end else begin
            comm = m_busy && m_t == lat(m_type);
            done = comm && !flush;
`ifdef TLB_REFETCH_EN
            exp_ref = done && m_type[1];
`else
            exp_ref = 1'b0;
`endif
            chk("busy", busy, m_busy);
            chk("op_ready", op_ready, !m_busy && !flush);
            chk("op_done", op_done, done);
            chk("tlbp_wen", tlbp_wen, done && m_type == 2'd1);
            chk("tlbr_wen", tlbr_wen, done && m_type == 2'd2);
            chk("w_en", w_en, m_busy && m_type == 2'd3 && m_t == 1 && !flush);
            chk("refetch", refetch, exp_ref);
            chk("s_vpn2", s_vpn2, m_ehi[31:13]);
            chk("s_asid", s_asid, m_ehi[7:0]);
            chk("r_index", r_index, m_idx);
            chk("w_index", w_index, m_idx);
            chk("w_entry", w_entry, m_went);
            chk("tlbp_index", tlbp_index, m_tp);
            chk("tlbr_entry", tlbr_entry, m_tr);
            if (w_en) mem[w_index] = w_entry;
            if (m_busy) begin
                if (flush) m_busy = 0;
                else begin
                    if (m_type == 2'd1 && m_t == 1) begin
                        sr = search(m_ehi[31:13], m_ehi[7:0]);
                        m_tp = sr[IW] ? 32'(sr[IW-1:0]) : 32'h8000_0000;
                    end
                    if (m_type == 2'd2 && m_t == 2) m_tr = mem[m_idx];
                    if (m_t == lat(m_type)) m_busy = 0;
                    else m_t++;
                end
            end else if (op_valid && !flush) begin
                m_busy = 1; m_t = 1; m_type = op_type; m_ehi = cp0_entryhi;
                m_idx = cp0_index; m_went = cp0_wentry;
            end
        end
        {s_found, s_index} = search(s_vpn2, s_asid);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an op in cycle 0 and returns in cycle 1 with the CP0 inputs scrambled.
    task automatic go(input logic [1:0] t, input logic [31:0] eh, input logic [IW-1:0] i, input logic [77:0] w);
        op_valid = 1; op_type = t; cp0_entryhi = eh; cp0_index = i; cp0_wentry = w;
        step();
        op_valid = 0; cp0_entryhi = $urandom; cp0_index = IW'($urandom);
        cp0_wentry = {$urandom, $urandom, 14'($urandom)};
    endtask

    initial begin
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_tlbp_index", tlbp_index, 0);
        chk("rst_tlbr_entry", tlbr_entry, 0);
        resetn = 1;
        step();
        // Load entries 5 and 3 through TLBWI, then TLBP hit on entry 5.
        go(2'd3, 32'h123440A5, 4'd5, mk(32'h123440A5, 51'h5A5A)); step(); step();
        go(2'd3, 32'h0, 4'd3, 78'h1_2345_6789_ABCD_EF01_23); step(); step();
        go(2'd1, 32'h123440A5, 4'd0, 78'h0);
        chk("p_busy", busy, 1);
        step();
        chk("hit_tlbp_wen", tlbp_wen, 1);
        chk("hit_op_done", op_done, 1);
        chk("hit_tlbp_index", tlbp_index, 32'h0000_0005);
        step();
        go(2'd1, 32'h0000_2011, 4'd0, 78'h0); step();
        chk("miss_tlbp_wen", tlbp_wen, 1);
        chk("miss_tlbp_index", tlbp_index, 32'h8000_0000);
        step();
        go(2'd2, 32'h0, 4'd3, 78'h0); step(); step();
        chk("rd_tlbr_wen", tlbr_wen, 1);
        chk("rd_tlbr_entry", tlbr_entry, 78'h1_2345_6789_ABCD_EF01_23);
`ifdef TLB_REFETCH_EN
        chk("rd_refetch", refetch, 1);
`else
        chk("rd_refetch", refetch, 0);
`endif
        step();
        e = 32'hDEADA03C;
        go(2'd3, e, 4'd7, mk(e, 51'h123));
        chk("wi_w_en", w_en, 1);
        chk("wi_w_index", w_index, 7);
        step();
        chk("wi_w_en_once", w_en, 0);
        step();
        chk("wi_p_ready", op_ready, 1);
        go(2'd1, e, 4'd0, 78'h0); step();
        chk("wi_p_index", tlbp_index, 32'h0000_0007);
        step();
        go(2'd3, 32'h0, 4'd9, 78'h0);
        flush = 1; #1;
        chk("fl_wi_w_en", w_en, 0);
        step(); flush = 0; #1;
        chk("fl_wi_ready", op_ready, 1);
        chk("fl_wi_done", op_done, 0);
        go(2'd2, 32'h0, 4'd4, 78'h0); step();
        flush = 1; #1;
        chk("fl_rd_tlbr_wen", tlbr_wen, 0);
        chk("fl_rd_done", op_done, 0);
        step(); flush = 0; #1;
        chk("fl_rd_ready", op_ready, 1);
        chk("fl_rd_tlbr_wen2", tlbr_wen, 0);
        go(2'd2, 32'hFFFF_FFFF, 4'd2, 78'h0); step();
        #2 resetn = 0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", op_ready, 1);
        chk("mid_rst_tlbr_entry", tlbr_entry, 0);
        chk("mid_rst_s_vpn2", s_vpn2, 0);
        chk("mid_rst_r_index", r_index, 0);
        chk("mid_rst_done", op_done | tlbr_wen | tlbp_wen | w_en | refetch, 0);
        @(negedge clk); @(posedge clk); #1 resetn = 1;
        step();
        chk("post_rst_ready", op_ready, 1);
        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 15);
            e = $urandom_range(0, 1) ? {mem[k][77:59], 5'($urandom), mem[k][58:51]} : $urandom;
            op_valid = $urandom_range(0, 1) == 1;
            op_type = 2'($urandom);
            cp0_entryhi = e;
            cp0_index = IW'($urandom);
            cp0_wentry = $urandom_range(0, 1) ? mk(e ^ 32'(($urandom_range(0, 1)) << 13), 51'($urandom)) : {$urandom, $urandom, 14'($urandom)};
            flush = $urandom_range(0, 9) == 0;
            step();
        end
        op_valid = 0; flush = 0;
        step(); step(); step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
